// File: rtl/mario_anim_pkg.sv
// Shared types and constants for the player-sprite animation sequencer.
// Pose encodings match the which_mario field consumed by the sprite ROM address logic.
package mario_anim_pkg;

  typedef enum logic [1:0] {
    STAND = 2'd0,
    WALK  = 2'd1,
    AIR   = 2'd2
  } anim_state_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam logic [1:0] POSE_STAND = 2'd0;
  localparam logic [1:0] POSE_W1    = 2'd1;
  localparam logic [1:0] POSE_W2    = 2'd2;
  localparam logic [1:0] POSE_W3    = 2'd3;

  // Walk cycle is 1->2->3->1; anything else restarts at the first walk frame.
  function automatic logic [1:0] next_walk_pose(input logic [1:0] pose);
    case (pose)
      POSE_W1: return POSE_W2;
      POSE_W2: return POSE_W3;
      default: return POSE_W1;
    endcase
  endfunction

endpackage

// File: rtl/anim_step_counter.sv
// Tick-enabled modulo-WALK_DIV step divider; wrap pulses combinationally on the enabled terminal count.
// Latency: count updates on the enabled edge; no backpressure (enable is a strobe).
module anim_step_counter #(
  parameter int unsigned WALK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic wrap
);

  localparam logic [3:0] LAST = 4'(WALK_DIV - 1);

  logic [3:0] div_q;
  logic [3:0] div_d;

  always_comb begin
    div_d = div_q;
    wrap  = 1'b0;
    if (clear) begin
      div_d = 4'd0;
    end else if (en) begin
      if (div_q == LAST) begin
        div_d = 4'd0;
        wrap  = 1'b1;
      end else begin
        div_d = div_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= 4'd0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/mario_anim_ctrl.sv
// Player sprite animation FSM: picks walk frame, facing and airborne pose once per frame tick.
// Latency: outputs registered, visible one cycle after the tick; no backpressure, non-tick cycles hold.
module mario_anim_ctrl
  import mario_anim_pkg::*;
#(
  parameter int unsigned WALK_DIV  = 4,
  parameter logic [7:0]  KEY_LEFT  = KEY_A,
  parameter logic [7:0]  KEY_RIGHT = KEY_D
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode2,
  input  logic       on_ground,
  output logic [1:0] which_mario,
  output logic       facing_left,
  output logic       jump_pose
);

  anim_state_t state_q, state_d;
  logic [1:0]  which_mario_q, which_mario_d;
  logic        facing_left_q, facing_left_d;
  logic        jump_pose_q, jump_pose_d;

  logic left, right, move;
  logic stay_walk, cnt_en, cnt_clear, cnt_wrap;

  assign left  = (keycode == KEY_LEFT)  || (keycode2 == KEY_LEFT);
  assign right = (keycode == KEY_RIGHT) || (keycode2 == KEY_RIGHT);
  assign move  = left ^ right;

  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      if (!on_ground)                      state_d = AIR;
      else if (state_q == AIR)             state_d = move ? WALK : STAND;
      else if (state_q == STAND && move)   state_d = WALK;
      else if (state_q == WALK && !move)   state_d = STAND;
    end
  end

  // Any tick that is not a WALK->WALK step zeroes the divider, so WALK always enters at div 0.
  assign stay_walk = (state_q == WALK) && (state_d == WALK);
  assign cnt_en    = frame_tick && stay_walk;
  assign cnt_clear = frame_tick && !stay_walk;

  anim_step_counter #(
    .WALK_DIV (WALK_DIV)
  ) u_step (
    .clk   (Clk),
    .reset (Reset),
    .en    (cnt_en),
    .clear (cnt_clear),
    .wrap  (cnt_wrap)
  );

  always_comb begin
    which_mario_d = which_mario_q;
    facing_left_d = facing_left_q;
    jump_pose_d   = jump_pose_q;
    if (frame_tick) begin
      jump_pose_d = (state_d == AIR);
      if (state_d != WALK)  which_mario_d = POSE_STAND;
      else if (!stay_walk)  which_mario_d = POSE_W1;
      else if (cnt_wrap)    which_mario_d = next_walk_pose(which_mario_q);
      if (move && on_ground) facing_left_d = left;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= STAND;
      which_mario_q <= POSE_STAND;
      facing_left_q <= 1'b0;
      jump_pose_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      which_mario_q <= which_mario_d;
      facing_left_q <= facing_left_d;
      jump_pose_q   <= jump_pose_d;
    end
  end

  assign which_mario = which_mario_q;
  assign facing_left = facing_left_q;
  assign jump_pose   = jump_pose_q;

endmodule

// File: doc/mario_anim_ctrl.md
# mario_anim_ctrl

Animation sequencer for the player sprite. It watches keyboard state and the physics ground flag, then chooses the walk-cycle frame, facing direction and airborne pose that the sprite ROM address logic consumes. The animation advances only on the per-frame tick, at a programmable rate. It sits between the USB keycode registers and the Mario sprite drawing block, and replaces free-running per-tick walk stepping.

## Interface
- `WALK_DIV`, default 4: frame ticks per walk-cycle step (legal range 1..15).
- `KEY_LEFT`, default 8'h04: HID code for the left key.
- `KEY_RIGHT`, default 8'h07: HID code for the right key.

Ports:
- `Clk` in 1: system clock, the only clock. Reset is synchronous and active-high.
- `Reset` in 1: synchronous, active-high reset.
- `frame_tick` in 1: single-`Clk` pulse, once per video frame.
- `keycode` in 8: first held HID key.
- `keycode2` in 8: second held HID key.
- `on_ground` in 1: from physics; 1 = feet on a surface.
- `which_mario` out 2: 0 = standing, 1..3 = walk frames.
- `facing_left` out 1: 1 = mirror the sprite horizontally.
- `jump_pose` out 1: 1 = select the airborne sprite.

## Operation
Input decode (combinational):
- `left` = either keycode equals `KEY_LEFT`; `right` likewise for `KEY_RIGHT`.
- `move` = `left` XOR `right`. Both held counts as no horizontal input.

States: `STAND`, `WALK`, `AIR`. State and outputs change only in a cycle where `frame_tick`=1; all other cycles hold.

Transitions, evaluated on each tick, in priority order:
1. `on_ground`=0, from any state → `AIR`.
2. `AIR` with `on_ground`=1 → `WALK` if `move`, else `STAND`.
3. `STAND` with `move` → `WALK`.
4. `WALK` without `move` → `STAND`.
5. Otherwise stay.

Step divider `div`:
- 4 bits, range 0..`WALK_DIV`-1.
- On entry to `WALK`: `div`=0 and `which_mario`=1.
- Staying in `WALK`: if `div`==`WALK_DIV`-1, set `div`=0 and advance the frame 1→2→3→1. Otherwise increment `div`.
- `which_mario` never takes the value 0 while in `WALK`.

Outputs by state:
- `STAND`: `which_mario`=0, `div`=0, `jump_pose`=0.
- `AIR`: `which_mario`=0, `jump_pose`=1, `div` held at 0.
- `WALK`: `jump_pose`=0; `which_mario` per the divider rules above.

Facing:
- On any tick with `move` and `on_ground`=1, `facing_left` ← `left`.
- Facing is frozen while airborne and when both direction keys are held.

## Timing
- All outputs are registered. They update on the `Clk` edge that samples `frame_tick`=1 and are visible one cycle later.
- Reset values: state `STAND`, `which_mario`=0, `facing_left`=0, `jump_pose`=0, `div`=0.
- `Reset` overrides a coincident `frame_tick`. Reset mid-walk or mid-air returns to the reset values with no residual divider count.
- Keycode changes between ticks are ignored; only values sampled in the tick cycle matter.
- With `WALK_DIV`=1, the frame advances on every tick after entry: 1,2,3,1,...
- Back-to-back ticks (`frame_tick` high on consecutive cycles) are legal. Each one is a full step.
- Landing while a direction is held restarts the walk cycle at frame 1. It does not resume the pre-jump frame.

## Structure
- Package `mario_anim_pkg` holds:
  - the state enum `anim_state_t` {`STAND`, `WALK`, `AIR`};
  - default key constants `KEY_A`=8'h04 and `KEY_D`=8'h07;
  - the `which_mario` encodings `POSE_STAND`, `POSE_W1`..`POSE_W3`.
- Sub-module `anim_step_counter`: a tick-enabled modulo-`WALK_DIV` counter with `clear` and `wrap` outputs. The FSM instantiates it once.
- The FSM uses the two-always style: a registered state process and a combinational next-state/output process. Outputs are registered separately from the combinational logic.

## Test plan
- **Reset release.** Reset for 2 cycles, then ticks with no keys → all outputs 0 and state `STAND`. Also assert reset together with a tick while walking → outputs return to 0 next cycle.
- **Walk cadence.** `WALK_DIV`=4, `keycode`=8'h07, 13 ticks → `which_mario` sequence 1,1,1,1,2,2,2,2,3,3,3,3,1, and `facing_left`=0 throughout.
- **Direction and conflict.** Hold 8'h04 for 1 tick → `facing_left`=1, `which_mario`=1. Then `keycode`=8'h04 with `keycode2`=8'h07 → `STAND`, `which_mario`=0, `facing_left` stays 1.
- **Jump.** Walking at frame 2, drop `on_ground` → next tick gives `jump_pose`=1 and `which_mario`=0. Switching keys to 8'h04 while airborne leaves `facing_left` unchanged. Landing with 8'h07 held → `which_mario`=1, `facing_left`=0.
- **Tick gating.** Change keycodes for 50 cycles with `frame_tick`=0 → no output change. Then 2 back-to-back ticks at `WALK_DIV`=1 → `which_mario` 1, then 2.
